// File: rtl/uart_wb_master.sv
// UART command front-end: 8N1 receiver, read/write frame parser and single-cycle Wishbone master.
// Frames: 0x57 addr data (write) or 0x52 addr (read); read data returned on rd_dat/rd_valid.
module uart_wb_master #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ACK_TIMEOUT  = 255,
    parameter int unsigned FRAME_GAP    = 20
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx,
    output logic       stb_o,
    output logic       we_o,
    output logic [7:0] adr_o,
    output logic [7:0] dat_o,
    input  logic [7:0] dat_i,
    input  logic       ack_i,
    output logic [7:0] rd_dat,
    output logic       rd_valid,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned ToW  = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned GapW = $clog2(FRAME_GAP + 2);

    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [ToW-1:0]  ToLast   = ToW'(ACK_TIMEOUT - 1);
    localparam logic [GapW-1:0] GapMax   = GapW'(FRAME_GAP + 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [1:0] {PsIdle, PsAddr, PsData, PsBus} ps_state_e;

    rx_state_e       rx_state_q;
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CntW-1:0] rx_cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            byte_valid_q, frame_err_q;

    ps_state_e       ps_state_q;
    logic            is_wr_q;
    logic [ToW-1:0]  to_cnt_q;
    logic [CntW-1:0] gap_tick_q;
    logic [GapW-1:0] gap_bits_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RxIdle;
            rx_cnt_q     <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            unique case (rx_state_q)
                RxIdle: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= RxStart;
                        rx_cnt_q   <= '0;
                    end
                end
                RxStart: begin
                    if (rx_cnt_q == HalfLast) begin
                        rx_cnt_q   <= '0;
                        bit_idx_q  <= '0;
                        // A start bit that is high again at mid-bit was a glitch.
                        rx_state_q <= rx_sync_q ? RxIdle : RxData;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RxData: begin
                    if (rx_cnt_q == BitLast) begin
                        rx_cnt_q  <= '0;
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) rx_state_q <= RxStop;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RxStop: begin
                    if (rx_cnt_q == BitLast) begin
                        byte_valid_q <= rx_sync_q;
                        frame_err_q  <= !rx_sync_q;
                        rx_state_q   <= RxIdle;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ps_state_q <= PsIdle;
            is_wr_q    <= 1'b0;
            to_cnt_q   <= '0;
            gap_tick_q <= '0;
            gap_bits_q <= '0;
            stb_o      <= 1'b0;
            we_o       <= 1'b0;
            adr_o      <= '0;
            dat_o      <= '0;
            rd_dat     <= '0;
            rd_valid   <= 1'b0;
            err        <= 1'b0;
            err_code   <= '0;
        end else begin
            rd_valid <= 1'b0;
            err      <= 1'b0;

            // Gap counts idle bit-times between bytes of a partial frame; saturates.
            if ((ps_state_q == PsAddr || ps_state_q == PsData) && rx_state_q == RxIdle &&
                !byte_valid_q) begin
                if (gap_tick_q == BitLast) begin
                    gap_tick_q <= '0;
                    if (gap_bits_q != GapMax) gap_bits_q <= gap_bits_q + 1'b1;
                end else begin
                    gap_tick_q <= gap_tick_q + 1'b1;
                end
            end else begin
                gap_tick_q <= '0;
                gap_bits_q <= '0;
            end

            unique case (ps_state_q)
                PsIdle: begin
                    if (byte_valid_q && (shift_q == 8'h57 || shift_q == 8'h52)) begin
                        is_wr_q    <= (shift_q == 8'h57);
                        ps_state_q <= PsAddr;
                    end
                end
                PsAddr: begin
                    if (byte_valid_q) begin
                        adr_o <= shift_q;
                        if (is_wr_q) begin
                            ps_state_q <= PsData;
                        end else begin
                            ps_state_q <= PsBus;
                            stb_o      <= 1'b1;
                            we_o       <= 1'b0;
                            dat_o      <= '0;
                            to_cnt_q   <= '0;
                        end
                    end else if (gap_bits_q == GapMax) begin
                        ps_state_q <= PsIdle;
                    end
                end
                PsData: begin
                    if (byte_valid_q) begin
                        dat_o      <= shift_q;
                        ps_state_q <= PsBus;
                        stb_o      <= 1'b1;
                        we_o       <= 1'b1;
                        to_cnt_q   <= '0;
                    end else if (gap_bits_q == GapMax) begin
                        ps_state_q <= PsIdle;
                    end
                end
                PsBus: begin
                    if (byte_valid_q) begin
                        err      <= 1'b1;
                        err_code <= 2'b11;
                    end
                    // Ack is checked first so it wins over a coincident timeout.
                    if (ack_i) begin
                        stb_o      <= 1'b0;
                        we_o       <= 1'b0;
                        ps_state_q <= PsIdle;
                        if (!is_wr_q) begin
                            rd_dat   <= dat_i;
                            rd_valid <= 1'b1;
                        end
                    end else if (to_cnt_q == ToLast) begin
                        stb_o      <= 1'b0;
                        we_o       <= 1'b0;
                        ps_state_q <= PsIdle;
                        err        <= 1'b1;
                        err_code   <= 2'b10;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
            endcase

            if (frame_err_q) begin
                err      <= 1'b1;
                err_code <= 2'b01;
                if (ps_state_q != PsBus) ps_state_q <= PsIdle;
            end
        end
    end

endmodule

// File: doc/uart_wb_master.md
Name: uart_wb_master

Overview:
- Command front-end on the LPC serial line (TX1 pin). Currently that pin is unused by the core.
- Receives 8N1 UART bytes and parses read/write command frames. Each frame becomes a single Wishbone cycle on the shared 8-bit channel bus.
- Read results are emitted as a byte strobe for the downstream serial return stage.
- Sits in parallel with krake_bus as a second bus master, upstream of the channel/clock-generator slaves.

Parameters:
- CLKS_PER_BIT, 434, clk_i cycles per UART bit (50 MHz / 115200). Minimum 4.
- ACK_TIMEOUT, 255, max clk_i cycles stb_o may stay high without ack_i.
- FRAME_GAP, 20, max idle bit-times between bytes of one frame before the parser discards the partial frame.

Ports:
- clk_i  in  1  system clock (GLA)
- rst_i  in  1  synchronous reset, active-high
- rx  in  1  UART serial input (TX1), asynchronous, idle high
- stb_o  out  1  Wishbone strobe
- we_o  out  1  Wishbone write enable
- adr_o  out  8  Wishbone address ([7:4] channel base, [3:0] register)
- dat_o  out  8  Wishbone write data
- dat_i  in  8  Wishbone read data (already muxed)
- ack_i  in  1  Wishbone acknowledge (already muxed)
- rd_dat  out  8  captured read data
- rd_valid  out  1  one-cycle pulse, rd_dat valid
- err  out  1  one-cycle error pulse
- err_code  out  2  01 framing, 10 ack timeout, 11 overrun; holds last value

Behaviour:
- Reset (synchronous): all outputs 0, rx synchronizer flops set to 1, UART RX and parser return to IDLE. Reset mid-transaction drops stb_o on the same edge and discards any partial frame.
- rx passes through a 2-flop synchronizer; all logic uses the synchronized value.
- UART RX FSM: IDLE -> START -> DATA -> STOP.
  - Falling edge enters START.
  - At CLKS_PER_BIT/2 the line is resampled; if high it is a glitch and the FSM returns to IDLE.
  - Data bits are sampled every CLKS_PER_BIT thereafter, LSB first, 8 bits.
  - Stop bit is sampled one bit-time after bit 7. If 1, byte_valid is pulsed on the next cycle. If 0, the byte is dropped, err is pulsed with code 01, and the parser is forced to IDLE.
  - RX returns to IDLE after the stop sample.
- Frame format:
  - Write: 0x57, addr, data.
  - Read: 0x52, addr.
  - Any other header byte is silently discarded; the parser stays in IDLE.
- Parser FSM: IDLE -> ADDR -> (DATA for writes) -> BUS -> IDLE.
  - A gap counter counts bit-times while in ADDR or DATA. When it exceeds FRAME_GAP, the parser returns to IDLE with no error.
- BUS state:
  - stb_o, we_o, adr_o and dat_o are registered. stb_o rises on the cycle after the byte_valid of the final frame byte.
  - For reads, dat_o is 0 and we_o is 0.
  - stb_o, we_o, adr_o and dat_o are held stable until ack_i is sampled high while stb_o is high.
  - On that edge stb_o deasserts, so each ack completes exactly one transfer.
  - Read: dat_i is captured into rd_dat on the ack edge; rd_valid pulses on the next cycle.
  - Write: no response.
- Timeout:
  - A counter starts at stb_o rise. If ACK_TIMEOUT cycles elapse without ack, stb_o drops, err pulses with code 10, and rd_valid does not fire.
  - ack_i and timeout on the same cycle: ack wins, no error.
- Overrun: a byte_valid arriving while in BUS is dropped, err pulses with code 11, and the bus cycle continues unaffected.
- ack_i asserted while stb_o is low is ignored.
- Back-to-back frames are supported. The parser accepts a new header as soon as BUS exits.
- Counters saturate or reload; none wraps into false events.

Test Plan:
All scenarios run with CLKS_PER_BIT=8.
- Write path: send 0x57,0x32,0xA5; slave acks 1 cycle after stb -> one stb_o pulse with we_o=1, adr_o=0x32, dat_o=0xA5. No rd_valid, no err.
- Read path: send 0x52,0x41; slave returns dat_i=0x3C with ack after 3 cycles -> stb_o high exactly 4 cycles, we_o=0, then rd_valid one cycle with rd_dat=0x3C.
- Timeout: send a read frame with the slave never acking (ACK_TIMEOUT=16) -> stb_o drops after 16 cycles, err pulses, err_code=10, no rd_valid. A following valid write frame completes normally.
- Framing error: send 0x57 then a byte with stop bit 0 -> err with code 01. The next 0x32,0xA5 is not executed because the parser was reset. A fresh full frame is executed.
- Noise and garbage:
  - Send header 0xFF, then a 1-bit-time/4 low glitch, then 0x52,0x10 -> only the read at 0x10 is issued.
  - A partial frame 0x57,0x20 followed by a gap of 25 bit-times -> discarded, no stb_o.
- Reset mid-cycle: assert rst_i for one cycle while stb_o is high -> stb_o, rd_valid and err are 0 at the next edge. A subsequent frame is decoded correctly.
